// File: rtl/hex_scroll_ctrl.sv
// Scrolling six-digit seven-segment banner fed from a synchronous character memory.
// Each accepted character enters on HEX0 and pushes the window one digit to the left.
module hex_scroll_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int TICK_DIV = 50000000
) (
  input  logic              CLOCK,
  input  logic              RESETn,
  input  logic              go,
  input  logic              stop,
  input  logic              pause,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX5,
  output logic              busy,
  output logic              empty
);

  localparam int              CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0]      BLANK     = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD
  } state_t;

  state_t                state;
  logic [ADDR_W-1:0]     ptr;
  logic [CNT_W-1:0]      tick;
  logic [5:0][7:0]       digits;

  // Only the eight letters this banner is meant to show light up; anything else is dark.
  function automatic logic [6:0] seg7(input logic [7:0] c);
    logic [6:0] s;
    case (c)
      8'd65:   s = 7'b0001000;
      8'd98:   s = 7'b0000011;
      8'd67:   s = 7'b1000110;
      8'd100:  s = 7'b0100001;
      8'd69:   s = 7'b0000110;
      8'd70:   s = 7'b0001110;
      8'd103:  s = 7'b0010000;
      8'd104:  s = 7'b0001011;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      state  <= IDLE;
      ptr    <= '0;
      tick   <= '0;
      busy   <= 1'b0;
      empty  <= 1'b0;
      digits <= {6{BLANK}};
    end else if (state != IDLE && stop) begin
      state  <= IDLE;
      ptr    <= '0;
      busy   <= 1'b0;
      digits <= {6{BLANK}};
    end else begin
      case (state)
        IDLE: begin
          ptr <= '0;
          if (go && !stop) begin
            state  <= FETCH;
            busy   <= 1'b1;
            empty  <= 1'b0;
            digits <= {6{BLANK}};
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          if (mem_data != 8'h00) begin
            digits <= {digits[4:0], mem_data};
            tick   <= '0;
            state  <= HOLD;
          end else if (ptr != '0) begin
            // Terminator mid-message: restart from the top without touching the display.
            ptr   <= '0;
            state <= FETCH;
          end else begin
            empty <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        HOLD: begin
          if (!pause) begin
            if (tick == TICK_LAST) begin
              ptr   <= ptr + ADDR_W'(1);
              state <= FETCH;
            end else begin
              tick <= tick + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_addr = ptr;
  assign HEX0     = seg7(digits[0]);
  assign HEX1     = seg7(digits[1]);
  assign HEX2     = seg7(digits[2]);
  assign HEX3     = seg7(digits[3]);
  assign HEX4     = seg7(digits[4]);
  assign HEX5     = seg7(digits[5]);

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Randomized bench for hex_scroll_ctrl against an edge-countdown reference model.
// The model tracks edges left until the next character is consumed rather than FSM states.
`timescale 1ns/1ps
module tb_hex_scroll_ctrl;

  localparam int ADDR_W   = 3;
  localparam int TICK_DIV = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              CLOCK = 1'b0;
  logic              RESETn = 1'b0;
  logic              go = 1'b0;
  logic              stop = 1'b0;
  logic              pause = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [6:0]        HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic              busy;
  logic              empty;
  logic [6:0]        hexObs [6];

  logic [7:0] mem [DEPTH];
  int vectors = 0;
  int miscompares = 0;

  bit         mRun;
  bit         mEmpty;
  int         mLeft;
  int         mPtr;
  logic [7:0] mWin [6];

  hex_scroll_ctrl #(.ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV)) dut (
    .CLOCK(CLOCK), .RESETn(RESETn), .go(go), .stop(stop), .pause(pause),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .busy(busy), .empty(empty)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) mem_data <= mem[mem_addr];

  assign hexObs[0] = HEX0;
  assign hexObs[1] = HEX1;
  assign hexObs[2] = HEX2;
  assign hexObs[3] = HEX3;
  assign hexObs[4] = HEX4;
  assign hexObs[5] = HEX5;

  function automatic logic [6:0] refSeg(input logic [7:0] c);
    case (c)
      "A":     return 7'b0001000;
      "b":     return 7'b0000011;
      "C":     return 7'b1000110;
      "d":     return 7'b0100001;
      "E":     return 7'b0000110;
      "F":     return 7'b0001110;
      "g":     return 7'b0010000;
      "h":     return 7'b0001011;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [7:0] randChar();
    case ($urandom_range(0, 11))
      0:       return "A";
      1:       return "b";
      2:       return "C";
      3:       return "d";
      4:       return "E";
      5:       return "F";
      6:       return "g";
      7:       return "h";
      8:       return 8'h5A;
      9:       return 8'h20;
      10:      return 8'h00;
      default: return 8'($urandom_range(1, 255));
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("HEX%0d", i), 32'(hexObs[i]), 32'(refSeg(mWin[i])));
    checkOutput("mem_addr", 32'(mem_addr), 32'(mPtr));
    checkOutput("busy", 32'(busy), 32'(mRun));
    checkOutput("empty", 32'(empty), 32'(mEmpty));
  endtask

  task automatic modelReset();
    mRun = 0; mEmpty = 0; mLeft = 0; mPtr = 0;
    for (int i = 0; i < 6; i++) mWin[i] = 8'h20;
  endtask

  task automatic blankWindow();
    for (int i = 0; i < 6; i++) mWin[i] = 8'h20;
  endtask

  // mLeft counts edges until the next character is consumed; above 2 the banner is holding.
  task automatic modelEdge(input bit g, input bit s, input bit p);
    logic [7:0] c;
    if (!mRun) begin
      mPtr = 0;
      if (g && !s) begin
        mRun = 1; mEmpty = 0; mLeft = 2;
        blankWindow();
      end
    end else if (s) begin
      mRun = 0; mPtr = 0;
      blankWindow();
    end else if (mLeft > 2) begin
      if (!p) begin
        if (mLeft == 3) mPtr = (mPtr + 1) % DEPTH;
        mLeft--;
      end
    end else if (mLeft == 2) begin
      mLeft = 1;
    end else begin
      c = mem[mPtr];
      if (c != 8'h00) begin
        for (int i = 5; i > 0; i--) mWin[i] = mWin[i-1];
        mWin[0] = c;
        mLeft = TICK_DIV + 2;
      end else if (mPtr != 0) begin
        mPtr = 0; mLeft = 2;
      end else begin
        mEmpty = 1; mRun = 0;
      end
    end
  endtask

  task automatic applyStimulus(input bit g, input bit s, input bit p);
    go = g; stop = s; pause = p;
    @(posedge CLOCK);
    if (RESETn) modelEdge(g, s, p);
    @(negedge CLOCK);
    checkAll();
  endtask

  task automatic runFree(input int n);
    repeat (n) applyStimulus(0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = randChar();
    mem[0] = "A"; mem[1] = "b"; mem[2] = 8'h00;
    modelReset();

    RESETn = 1'b0; go = 1'b1;
    repeat (2) @(negedge CLOCK);
    checkAll();
    RESETn = 1'b1;
    applyStimulus(1, 0, 0);
    runFree(30);

    runFree(3);
    repeat (10) applyStimulus(0, 0, 1);
    runFree(12);

    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 0);
    runFree(5);
    applyStimulus(0, 1, 0);
    runFree(2);

    mem[0] = 8'h00;
    applyStimulus(1, 0, 0);
    runFree(4);
    mem[0] = "C";
    applyStimulus(1, 0, 0);
    runFree(3);
    applyStimulus(0, 1, 0);

    for (int i = 0; i < DEPTH; i++) mem[i] = (i == 5) ? 8'h5A : refSegChar(i);
    applyStimulus(1, 0, 0);
    runFree(DEPTH * (TICK_DIV + 2) + 15);

    #2 RESETn = 1'b0;
    #1 modelReset();
    checkAll();
    @(negedge CLOCK);
    RESETn = 1'b1;
    checkAll();

    for (int n = 0; n < 2500; n++) begin
      if (!mRun && $urandom_range(0, 9) == 0)
        for (int i = 0; i < DEPTH; i++) mem[i] = randChar();
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic logic [7:0] refSegChar(input int i);
    case (i % 8)
      0:       return "C";
      1:       return "d";
      2:       return "E";
      3:       return "F";
      4:       return "g";
      5:       return "h";
      6:       return "A";
      default: return "b";
    endcase
  endfunction

endmodule
